// File: rtl/sensor_ctrl.sv
// Sensor capture controller: fills a DEPTH-entry buffer from the sensor and interrupts the CPU when full.
// Optional macro SCTRL_COUNT_EN exposes the registered fill count on port sctrl_count.
module sensor_ctrl #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sctrl_en,
    input  logic          sctrl_clear,
    input  logic [AW-1:0] sctrl_addr,
    output logic [31:0]   sctrl_out,
    output logic          sctrl_interrupt,
    input  logic          sensor_ready,
    input  logic [31:0]   sensor_out,
`ifdef SCTRL_COUNT_EN
    output logic [AW:0]   sctrl_count,
`endif
    output logic          sensor_en
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    logic [1:0]  state_q, state_d;
    logic [AW:0] count_q, count_d;
    logic        wr_en;
    logic [31:0] rd_data_q, rd_data_d;
    logic [31:0] mem [DEPTH];

    // Clear dominates everything; a word arriving on the clearing edge is dropped.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wr_en   = 1'b0;
        if (sctrl_clear) begin
            state_d = S_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sctrl_en) state_d = (count_q == FULL_CNT) ? S_FULL : S_FILL;
                end
                S_FILL: begin
                    if (sensor_ready) begin
                        wr_en   = 1'b1;
                        count_d = count_q + ONE_CNT;
                    end
                    if (count_d == FULL_CNT) state_d = S_FULL;
                    else if (!sctrl_en)      state_d = S_IDLE;
                end
                S_FULL:  state_d = S_FULL;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values; this also
    // makes a same-edge write to the read address return the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // NOTE: the buffer array has no reset so it maps onto RAM; its contents survive clear and rst.
    always_ff @(posedge clk) begin
        if (wr_en) mem[count_q[AW-1:0]] <= sensor_out;
    end

    always_comb begin
        rd_data_d = mem[sctrl_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= rd_data_d;
    end

    assign sctrl_out       = rd_data_q;
    assign sensor_en       = (state_q == S_FILL);
    assign sctrl_interrupt = (state_q == S_FULL);

`ifdef SCTRL_COUNT_EN
    assign sctrl_count = count_q;
`else
    // Count stays internal when the optional port is not built.
`endif

endmodule

// File: tb/tb_sensor_ctrl.sv
// Directed self-checking bench for sensor_ctrl; inputs driven and outputs sampled on the falling clock edge.
// Define SCTRL_COUNT_EN for this file and the RTL to also check the optional count port.
module tb_sensor_ctrl;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk;
    logic          rst;
    logic          sctrl_en;
    logic          sctrl_clear;
    logic [AW-1:0] sctrl_addr;
    logic [31:0]   sctrl_out;
    logic          sctrl_interrupt;
    logic          sensor_ready;
    logic [31:0]   sensor_out;
    logic          sensor_en;
`ifdef SCTRL_COUNT_EN
    logic [AW:0]   sctrl_count;
`endif

    int checks = 0;
    int errors = 0;

    sensor_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
`ifdef SCTRL_COUNT_EN
        .sctrl_count     (sctrl_count),
`endif
        .clk             (clk),
        .rst             (rst),
        .sctrl_en        (sctrl_en),
        .sctrl_clear     (sctrl_clear),
        .sctrl_addr      (sctrl_addr),
        .sctrl_out       (sctrl_out),
        .sctrl_interrupt (sctrl_interrupt),
        .sensor_ready    (sensor_ready),
        .sensor_out      (sensor_out),
        .sensor_en       (sensor_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-cycle sensor word, starting and ending on a falling edge.
    task automatic pulse_word(input logic [31:0] d);
        sensor_ready = 1'b1;
        sensor_out   = d;
        @(negedge clk);
        sensor_ready = 1'b0;
    endtask

    task automatic read_word(input logic [AW-1:0] a, output logic [31:0] d);
        sctrl_addr = a;
        @(negedge clk);
        d = sctrl_out;
    endtask

    task automatic test_reset;
        rst = 1'b1; sctrl_en = 1'b0; sctrl_clear = 1'b0; sctrl_addr = '0;
        sensor_ready = 1'b0; sensor_out = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (sensor_en !== 1'b0) begin errors++; $display("FAIL reset_sensor_en: got %0b want 0", sensor_en); end
        checks++;
        if (sctrl_interrupt !== 1'b0) begin errors++; $display("FAIL reset_interrupt: got %0b want 0", sctrl_interrupt); end
        checks++;
        if (sctrl_out !== 32'h0) begin errors++; $display("FAIL reset_sctrl_out: got %h want 0", sctrl_out); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (sensor_en !== 1'b0) begin errors++; $display("FAIL idle_no_en: got %0b want 0", sensor_en); end
    endtask

    task automatic test_fill;
        logic [31:0] d;
        sctrl_en = 1'b1;
        @(negedge clk);
        checks++;
        if (sensor_en !== 1'b1) begin errors++; $display("FAIL fill_sensor_en: got %0b want 1", sensor_en); end
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) begin
                checks++;
                if (sctrl_interrupt !== 1'b0 || sensor_en !== 1'b1) begin
                    errors++;
                    $display("FAIL fill_before_last: irq %0b en %0b want 0 1", sctrl_interrupt, sensor_en);
                end
            end
            pulse_word(32'h1000 + 32'(i));
`ifdef SCTRL_COUNT_EN
            checks++;
            if (sctrl_count !== 7'(i + 1)) begin errors++; $display("FAIL count_track: got %0d want %0d", sctrl_count, i + 1); end
`endif
            if (i != DEPTH - 1) repeat (3) @(negedge clk);
        end
        checks++;
        if (sensor_en !== 1'b0 || sctrl_interrupt !== 1'b1) begin
            errors++;
            $display("FAIL fill_full: en %0b irq %0b want 0 1", sensor_en, sctrl_interrupt);
        end
        read_word(6'd5, d);
        checks++;
        if (d !== 32'h0000_1005) begin errors++; $display("FAIL read_idx5: got %h want 00001005", d); end
        read_word(6'd0, d);
        checks++;
        if (d !== 32'h0000_1000) begin errors++; $display("FAIL read_idx0: got %h want 00001000", d); end
    endtask

    task automatic test_full_ignore;
        logic [31:0] d;
        sensor_ready = 1'b1;
        sensor_out   = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            sctrl_en = i[0];
            @(negedge clk);
            checks++;
            if (sctrl_interrupt !== 1'b1 || sensor_en !== 1'b0) begin
                errors++;
                $display("FAIL full_hold: cycle %0d irq %0b en %0b want 1 0", i, sctrl_interrupt, sensor_en);
            end
        end
        sensor_ready = 1'b0;
        sctrl_en     = 1'b1;
        read_word(6'd63, d);
        checks++;
        if (d !== 32'h0000_103F) begin errors++; $display("FAIL full_buf63: got %h want 0000103F", d); end
`ifdef SCTRL_COUNT_EN
        checks++;
        if (sctrl_count !== 7'd64) begin errors++; $display("FAIL count_full: got %0d want 64", sctrl_count); end
`endif
    endtask

    task automatic test_pause;
        logic [31:0] d;
        sctrl_en    = 1'b0;
        sctrl_clear = 1'b1;
        @(negedge clk);
        sctrl_clear = 1'b0;
        checks++;
        if (sctrl_interrupt !== 1'b0 || sensor_en !== 1'b0) begin
            errors++;
            $display("FAIL clear_from_full: irq %0b en %0b want 0 0", sctrl_interrupt, sensor_en);
        end
`ifdef SCTRL_COUNT_EN
        checks++;
        if (sctrl_count !== 7'd0) begin errors++; $display("FAIL count_clear: got %0d want 0", sctrl_count); end
`endif
        sctrl_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            pulse_word(32'h3000 + 32'(i));
            repeat (3) @(negedge clk);
        end
        sctrl_en = 1'b0;
        @(negedge clk);
        checks++;
        if (sensor_en !== 1'b0) begin errors++; $display("FAIL pause_en_low: got %0b want 0", sensor_en); end
        // Words offered while idle must be ignored.
        for (int k = 0; k < 50; k++) begin
            sensor_ready = (k % 5 == 0);
            sensor_out   = 32'hFFFF_0000 + 32'(k);
            @(negedge clk);
        end
        sensor_ready = 1'b0;
        sctrl_en     = 1'b1;
        @(negedge clk);
        checks++;
        if (sensor_en !== 1'b1) begin errors++; $display("FAIL resume_en: got %0b want 1", sensor_en); end
        for (int i = 20; i < DEPTH; i++) begin
            if (i == DEPTH - 1) begin
                checks++;
                if (sctrl_interrupt !== 1'b0) begin errors++; $display("FAIL pause_early_irq: got 1 want 0"); end
            end
            pulse_word(32'h3000 + 32'(i));
            if (i != DEPTH - 1) repeat (3) @(negedge clk);
        end
        checks++;
        if (sctrl_interrupt !== 1'b1) begin errors++; $display("FAIL pause_irq: got %0b want 1", sctrl_interrupt); end
        read_word(6'd20, d);
        checks++;
        if (d !== 32'h0000_3014) begin errors++; $display("FAIL pause_idx20: got %h want 00003014", d); end
        read_word(6'd19, d);
        checks++;
        if (d !== 32'h0000_3013) begin errors++; $display("FAIL pause_idx19: got %h want 00003013", d); end
        read_word(6'd63, d);
        checks++;
        if (d !== 32'h0000_303F) begin errors++; $display("FAIL pause_idx63: got %h want 0000303F", d); end
    endtask

    task automatic test_back_to_back_clear_race;
        logic [31:0] d;
        sctrl_en    = 1'b0;
        sctrl_clear = 1'b1;
        @(negedge clk);
        sctrl_clear = 1'b0;
        sctrl_en    = 1'b1;
        @(negedge clk);
        sensor_ready = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            sensor_out = 32'h2000 + 32'(i);
            @(negedge clk);
        end
        // Count is 63: the clear and the final word meet on the same edge.
        sctrl_clear = 1'b1;
        sctrl_en    = 1'b0;
        sensor_out  = 32'hBAD0_BAD0;
        @(negedge clk);
        sctrl_clear  = 1'b0;
        sensor_ready = 1'b0;
        checks++;
        if (sctrl_interrupt !== 1'b0 || sensor_en !== 1'b0) begin
            errors++;
            $display("FAIL race_state: irq %0b en %0b want 0 0", sctrl_interrupt, sensor_en);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (sctrl_interrupt !== 1'b0) begin errors++; $display("FAIL race_irq_late: cycle %0d got 1 want 0", k); end
        end
        read_word(6'd63, d);
        checks++;
        if (d !== 32'h0000_303F) begin errors++; $display("FAIL race_idx63: got %h want 0000303F", d); end
        read_word(6'd62, d);
        checks++;
        if (d !== 32'h0000_203E) begin errors++; $display("FAIL race_idx62: got %h want 0000203E", d); end
        // Restart from entry 0 while reading it: first read returns the old word.
        sctrl_addr = 6'd0;
        sctrl_en   = 1'b1;
        @(negedge clk);
        checks++;
        if (sensor_en !== 1'b1) begin errors++; $display("FAIL race_restart_en: got %0b want 1", sensor_en); end
        pulse_word(32'h0000_4000);
        checks++;
        if (sctrl_out !== 32'h0000_2000) begin errors++; $display("FAIL same_edge_old: got %h want 00002000", sctrl_out); end
        @(negedge clk);
        checks++;
        if (sctrl_out !== 32'h0000_4000) begin errors++; $display("FAIL same_edge_new: got %h want 00004000", sctrl_out); end
`ifdef SCTRL_COUNT_EN
        checks++;
        if (sctrl_count !== 7'd1) begin errors++; $display("FAIL count_restart: got %0d want 1", sctrl_count); end
`endif
    endtask

    task automatic test_async_reset;
        logic [31:0] d;
        pulse_word(32'h0000_5001);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (sensor_en !== 1'b0 || sctrl_interrupt !== 1'b0 || sctrl_out !== 32'h0) begin
            errors++;
            $display("FAIL async_rst: en %0b irq %0b out %h want 0 0 0", sensor_en, sctrl_interrupt, sctrl_out);
        end
        sctrl_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sensor_en !== 1'b0) begin errors++; $display("FAIL post_rst_idle: got %0b want 0", sensor_en); end
        sctrl_en = 1'b1;
        @(negedge clk);
        pulse_word(32'h0000_6000);
        read_word(6'd0, d);
        checks++;
        if (d !== 32'h0000_6000) begin errors++; $display("FAIL post_rst_idx0: got %h want 00006000", d); end
        read_word(6'd1, d);
        checks++;
        if (d !== 32'h0000_5001) begin errors++; $display("FAIL post_rst_idx1: got %h want 00005001", d); end
        read_word(6'd2, d);
        checks++;
        if (d !== 32'h0000_2002) begin errors++; $display("FAIL post_rst_idx2: got %h want 00002002", d); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_ignore();
        test_pause();
        test_back_to_back_clear_race();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sensor_ctrl.md
SENSOR_CTRL -- requirements
Module: sensor_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit buffer entries (power of two, 4..256).
REQ-002 SHALL have parameter AW, default 6, buffer address width, equal to log2(DEPTH).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 sctrl_en  input  1  CPU-side enable; collection runs while high.
REQ-006 sctrl_clear  input  1  CPU-side clear of count, state and interrupt.
REQ-007 sctrl_addr  input  AW  buffer read index.
REQ-008 sctrl_out  output  32  registered buffer read data.
REQ-009 sctrl_interrupt  output  1  buffer-full interrupt to CPU.
REQ-010 sensor_ready  input  1  sensor word valid this cycle.
REQ-011 sensor_out  input  32  sensor data word.
REQ-012 sensor_en  output  1  request to sensor to produce data.

Function
REQ-013 SHALL implement states IDLE, FILL, FULL; sensor_en = (state==FILL); sctrl_interrupt = (state==FULL); both decoded from registered state, no combinational path from inputs.
REQ-014 IDLE->FILL when sctrl_en=1 and count<DEPTH; IDLE->FULL when sctrl_en=1 and count==DEPTH.
REQ-015 FILL->IDLE when sctrl_en=0; count and buffer contents retained.
REQ-016 In FILL, sensor_ready=1 at a rising edge SHALL write sensor_out to buf[count] and increment count (AW+1 bits).
REQ-017 Write of entry DEPTH-1 SHALL move FILL->FULL in the same edge; sensor_en low and sctrl_interrupt high from the next cycle.
REQ-018 sensor_ready while state!=FILL SHALL be ignored (no write, no count change).
REQ-019 FULL SHALL hold until sctrl_clear; sctrl_en toggling in FULL has no effect.
REQ-020 sctrl_clear=1 in any state SHALL set count=0, state=IDLE at that edge; clear wins over a simultaneous sensor_ready (word dropped) and over sctrl_en.
REQ-021 Buffer contents SHALL NOT be erased by clear or reset (reads of unwritten entries are don't-care).
REQ-022 sctrl_out SHALL equal buf[sctrl_addr] one cycle after sctrl_addr is presented; a same-edge write to the addressed entry returns the old value.
REQ-023 Count SHALL never exceed DEPTH and SHALL not wrap.

Reset
REQ-024 On rst: state=IDLE, count=0, sctrl_out=0, sensor_en=0, sctrl_interrupt=0, held while rst high regardless of clk.
REQ-025 Reset asserted mid-FILL SHALL abort collection; after release the block needs sctrl_en to restart from entry 0.

Configuration
REQ-026 Macro SCTRL_COUNT_EN: when defined, adds output sctrl_count (AW+1 bits) equal to registered count, reset 0; when undefined the port and its logic are absent and all other behaviour is identical.

Verification
REQ-027 Reset, sctrl_en=1, sensor_ready pulsed every 4th cycle with data 0x1000+i -> after 64 writes sensor_en=0, sctrl_interrupt=1; sctrl_addr=5 returns 0x00001005 one cycle later.
REQ-028 In FULL, sensor_ready=1 with 0xDEADBEEF for 10 cycles -> no buffer change, buf[63]=0x0000103F, interrupt stays 1.
REQ-029 sctrl_en dropped after 20 writes, raised again 50 cycles later -> next word lands at index 20; total 64 writes before interrupt.
REQ-030 sctrl_clear and sensor_ready same edge at count=63 -> count=0, state IDLE, interrupt never asserted, buf[63] unchanged.
REQ-031 rst asserted asynchronously mid-FILL between clk edges -> sensor_en and sctrl_interrupt drop immediately; count=0 after release.
REQ-032 With SCTRL_COUNT_EN defined, sctrl_count reads 0,1,..,64 tracking each accepted write and returns to 0 on sctrl_clear.
